// File: rtl/platform_manager.sv
// Platform table for the doodle game: fills, scrolls and regenerates platform slots on request
// from the game FSM. Define PLAT_MOVING_EN to make odd slots drift horizontally on frame_tick.
module platform_manager #(
    parameter int          NUM_PLAT    = 8,
    parameter int          SCREEN_H    = 480,
    parameter int          SCREEN_W    = 640,
    parameter int          PLAT_W      = 64,
    parameter int          Y_SPACING   = 60,
    parameter int          SCROLL_LINE = 160,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        frame_tick,
    input  logic [2:0]                  outstate,
    input  logic                        loadplat,
    input  logic [9:0]                  doodle_y,
    input  logic [$clog2(NUM_PLAT)-1:0] rd_idx,
    output logic [9:0]                  rd_x,
    output logic [9:0]                  rd_y,
    output logic                        rd_valid,
    output logic                        refresh_en,
    output logic                        trigger
);

    localparam int IDX_W = $clog2(NUM_PLAT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);
    localparam logic [9:0]       MAX_X    = 10'(SCREEN_W - PLAT_W);
    localparam logic [9:0]       CENTER_X = 10'((SCREEN_W - PLAT_W) / 2);
    localparam logic [9:0]       SCR_LINE = 10'(SCROLL_LINE);
    localparam logic [10:0]      H11      = 11'(SCREEN_H);
    localparam logic [15:0]      LFSR_MASK = 16'hB400;

    localparam logic [2:0] OS_MENU    = 3'b000;
    localparam logic [2:0] OS_GAME    = 3'b010;
    localparam logic [2:0] OS_REFRESH = 3'b100;
    localparam logic [2:0] OS_INIT    = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        SCROLL,
        DONE
    } state_t;

    state_t state, next_state;

    logic [9:0]          x_mem [NUM_PLAT];
    logic [9:0]          y_mem [NUM_PLAT];
    logic [NUM_PLAT-1:0] valid_mem;

    logic [15:0]      lfsr;
    logic [IDX_W-1:0] cnt;
    logic [9:0]       shift;
    logic             abort_pend;

    logic        abort;
    logic        cnt_clr, cnt_inc, shift_load, clear_all;
    logic        wr_en, wr_x_en, wr_set_valid;
    logic [9:0]  wr_x, wr_y;
    logic [9:0]  rand_x, fill_y, shift_next;
    logic [10:0] scroll_sum;

    assign abort = (outstate == OS_MENU) || (outstate == OS_INIT);

    // Fold the 10-bit random value into the legal x range with a single subtraction.
    always_comb begin
        rand_x = lfsr[9:0];
        if (lfsr[9:0] >= MAX_X) begin
            rand_x = lfsr[9:0] - MAX_X;
        end
    end

    assign fill_y     = 10'(SCREEN_H - 20 - int'(cnt) * Y_SPACING);
    assign shift_next = (doodle_y < SCR_LINE) ? (SCR_LINE - doodle_y) : 10'd0;
    assign scroll_sum = {1'b0, y_mem[cnt]} + {1'b0, shift};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        shift_load   = 1'b0;
        clear_all    = 1'b0;
        wr_en        = 1'b0;
        wr_x_en      = 1'b0;
        wr_set_valid = 1'b0;
        wr_x         = rand_x;
        wr_y         = fill_y;
        trigger      = 1'b0;
        case (state)
            IDLE: begin
                clear_all = 1'b1;
                if (!abort && loadplat) begin
                    next_state = FILL;
                    cnt_clr    = 1'b1;
                end
            end
            FILL: begin
                wr_en        = 1'b1;
                wr_x_en      = 1'b1;
                wr_set_valid = 1'b1;
                wr_x         = (cnt == '0) ? CENTER_X : rand_x;
                wr_y         = fill_y;
                cnt_inc      = 1'b1;
                // A menu/init request seen during the fill is honoured once the table is complete.
                if (cnt == LAST_IDX) begin
                    next_state = (abort || abort_pend) ? IDLE : READY;
                end
            end
            READY: begin
                if (abort) begin
                    next_state = IDLE;
                    clear_all  = 1'b1;
                end else if (loadplat) begin
                    next_state = FILL;
                    cnt_clr    = 1'b1;
                end else if (outstate == OS_REFRESH) begin
                    next_state = SCROLL;
                    cnt_clr    = 1'b1;
                    shift_load = 1'b1;
                end
            end
            SCROLL: begin
                if (abort) begin
                    next_state = IDLE;
                    clear_all  = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    // Wrapping by exactly SCREEN_H keeps the slot spacing intact.
                    if (scroll_sum >= H11) begin
                        wr_x_en = 1'b1;
                        wr_x    = rand_x;
                        wr_y    = 10'(scroll_sum - H11);
                    end else begin
                        wr_y = scroll_sum[9:0];
                    end
                    if (cnt == LAST_IDX) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                trigger = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                    clear_all  = 1'b1;
                end else begin
                    next_state = READY;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt        <= '0;
            shift      <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (shift_load) begin
                shift <= shift_next;
            end
            if (state == FILL) begin
                abort_pend <= abort_pend | abort;
            end else begin
                abort_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_en <= 1'b0;
        end else begin
            refresh_en <= (state == READY) && (outstate == OS_GAME) && (doodle_y < SCR_LINE);
        end
    end

`ifdef PLAT_MOVING_EN
    logic [NUM_PLAT-1:0] dir_mem;
    logic [NUM_PLAT-1:0] wr_mask;

    always_comb begin
        wr_mask      = '0;
        wr_mask[cnt] = wr_en;
    end

    // Odd slots bounce between the playfield edges; a FILL/SCROLL write to a slot overrides its move.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
            valid_mem <= '0;
            dir_mem   <= '1;
        end else begin
            if (frame_tick && (outstate == OS_GAME)) begin
                for (int i = 1; i < NUM_PLAT; i += 2) begin
                    if (valid_mem[i] && !wr_mask[i]) begin
                        if (dir_mem[i]) begin
                            if (x_mem[i] >= MAX_X) begin
                                x_mem[i]   <= x_mem[i] - 10'd1;
                                dir_mem[i] <= 1'b0;
                            end else begin
                                x_mem[i] <= x_mem[i] + 10'd1;
                            end
                        end else begin
                            if (x_mem[i] == 10'd0) begin
                                x_mem[i]   <= 10'd1;
                                dir_mem[i] <= 1'b1;
                            end else begin
                                x_mem[i] <= x_mem[i] - 10'd1;
                            end
                        end
                    end
                end
            end
            if (wr_en) begin
                y_mem[cnt] <= wr_y;
                if (wr_x_en) begin
                    x_mem[cnt]   <= wr_x;
                    dir_mem[cnt] <= 1'b1;
                end
                if (wr_set_valid) begin
                    valid_mem[cnt] <= 1'b1;
                end
            end
            if (clear_all) begin
                valid_mem <= '0;
            end
        end
    end
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
            valid_mem <= '0;
        end else begin
            if (wr_en) begin
                y_mem[cnt] <= wr_y;
                if (wr_x_en) begin
                    x_mem[cnt] <= wr_x;
                end
                if (wr_set_valid) begin
                    valid_mem[cnt] <= 1'b1;
                end
            end
            if (clear_all) begin
                valid_mem <= '0;
            end
        end
    end
`endif

    // Registered read port: a same-cycle write to the addressed slot is not yet visible.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_x     <= x_mem[rd_idx];
            rd_y     <= y_mem[rd_idx];
            rd_valid <= valid_mem[rd_idx];
        end
    end

endmodule
